// File: rtl/pipe_pal_sched.sv
// Round-robin scheduler sharing one pipe_pal datapath input among N_REQ requesters.
// Grants one requester per burst (up to MAX_BURST beats) through a single registered output stage.
module pipe_pal_sched #(
   parameter int W_DATA    = 32,
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 4,
   localparam int W_SRC    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [N_REQ-1:0]        i_req_valid,
   input  logic [N_REQ*W_DATA-1:0] i_req_data,
   input  logic [N_REQ-1:0]        i_req_last,
   output logic [N_REQ-1:0]        o_req_ready,
   output logic                    o_valid,
   output logic [W_DATA-1:0]       o_data,
   output logic [W_SRC-1:0]        o_src,
   output logic                    o_last,
   input  logic                    i_ready,
   output logic                    o_busy
);

   localparam int W_CNT = $clog2(MAX_BURST + 1);
   localparam logic [W_CNT:0]   BURST_LIMIT = (W_CNT + 1)'(MAX_BURST);
   localparam logic [W_SRC:0]   N_REQ_EXT   = (W_SRC + 1)'(N_REQ);
   localparam logic [W_SRC-1:0] LAST_IDX    = W_SRC'(N_REQ - 1);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t            state_reg, state_next;
   logic [W_SRC-1:0]  owner_reg, owner_next;
   logic [W_SRC-1:0]  rr_ptr_reg, rr_ptr_next;
   logic [W_CNT-1:0]  beat_cnt_reg, beat_cnt_next;
   logic [W_CNT:0]    beat_cnt_inc;
   logic [W_SRC-1:0]  pick;
   logic [W_SRC:0]    scan_idx;
   logic              any_valid;
   logic              accept;
   logic              beat_last;
   logic [W_DATA-1:0] req_data_arr [N_REQ];

   generate
      for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign req_data_arr[gi] = i_req_data[gi*W_DATA +: W_DATA];
      end
   endgenerate

   // First valid requester scanning upward from rr_ptr, wrapping at N_REQ-1.
   always_comb begin
      any_valid = 1'b0;
      pick      = rr_ptr_reg;
      scan_idx  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         scan_idx = {1'b0, rr_ptr_reg} + (W_SRC + 1)'(i);
         if (scan_idx >= N_REQ_EXT)
            scan_idx = scan_idx - N_REQ_EXT;
         if (!any_valid && i_req_valid[scan_idx[W_SRC-1:0]]) begin
            any_valid = 1'b1;
            pick      = scan_idx[W_SRC-1:0];
         end
      end
   end

   assign beat_cnt_inc = {1'b0, beat_cnt_reg} + (W_CNT + 1)'(1);
   assign beat_last    = i_req_last[owner_reg] || (beat_cnt_inc == BURST_LIMIT);
   assign accept       = (state_reg == GRANT) && i_req_valid[owner_reg] && o_req_ready[owner_reg];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg    <= IDLE;
         owner_reg    <= '0;
         rr_ptr_reg   <= '0;
         beat_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         owner_reg    <= owner_next;
         rr_ptr_reg   <= rr_ptr_next;
         beat_cnt_reg <= beat_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      owner_next    = owner_reg;
      rr_ptr_next   = rr_ptr_reg;
      beat_cnt_next = beat_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (any_valid) begin
               owner_next    = pick;
               beat_cnt_next = '0;
               state_next    = GRANT;
            end
         end
         GRANT: begin
            if (accept) begin
               beat_cnt_next = beat_cnt_inc[W_CNT-1:0];
               if (beat_last) begin
                  state_next  = IDLE;
                  rr_ptr_next = (owner_reg == LAST_IDX) ? '0 : owner_reg + W_SRC'(1);
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Ready is masked during reset so no handshake can complete in the reset cycle.
   always_comb begin
      o_req_ready = '0;
      o_busy      = (state_reg == GRANT);
      if (state_reg == GRANT && !i_rst)
         o_req_ready[owner_reg] = !o_valid || i_ready;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_valid <= 1'b0;
         o_data  <= '0;
         o_src   <= '0;
         o_last  <= 1'b0;
      end else if (accept) begin
         o_valid <= 1'b1;
         o_data  <= req_data_arr[owner_reg];
         o_src   <= owner_reg;
         o_last  <= beat_last;
      end else if (i_ready) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pipe_pal_sched.sv
// Directed bench for pipe_pal_sched: requester models feed beats, a scoreboard queue
// holds the expected output order and is checked on every drained output beat.
module tb_pipe_pal_sched;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int MB = 4;

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic [N-1:0]     i_req_valid;
   logic [N*W-1:0]   i_req_data;
   logic [N-1:0]     i_req_last;
   logic [N-1:0]     o_req_ready;
   logic             o_valid;
   logic [W-1:0]     o_data;
   logic [1:0]       o_src;
   logic             o_last;
   logic             i_ready;
   logic             o_busy;

   always #5 i_clk = ~i_clk;

   pipe_pal_sched #(.W_DATA(W), .N_REQ(N), .MAX_BURST(MB)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_req_valid (i_req_valid),
      .i_req_data  (i_req_data),
      .i_req_last  (i_req_last),
      .o_req_ready (o_req_ready),
      .o_valid     (o_valid),
      .o_data      (o_data),
      .o_src       (o_src),
      .o_last      (o_last),
      .i_ready     (i_ready),
      .o_busy      (o_busy)
   );

   int           n_tests = 0;
   int           n_fail  = 0;
   int           out_cnt = 0;
   int           base;
   logic [W-1:0] mem_d [N][16];
   logic         mem_l [N][16];
   int           rd_ptr [N];
   int           wr_cnt [N];
   logic [N-1:0] en;
   logic [W+2:0] exp_q [$];
   logic [3:0]   exp_rdy;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int k, input logic [W-1:0] d, input logic l);
      mem_d[k][wr_cnt[k]] = d;
      mem_l[k][wr_cnt[k]] = l;
      wr_cnt[k]++;
   endtask

   task automatic expect_beat(input logic [1:0] s, input logic l, input logic [W-1:0] d);
      exp_q.push_back({s, l, d});
   endtask

   task automatic drive_reqs();
      for (int k = 0; k < N; k++) begin
         if (en[k] && rd_ptr[k] < wr_cnt[k]) begin
            i_req_valid[k]     = 1'b1;
            i_req_data[k*W +: W] = mem_d[k][rd_ptr[k]];
            i_req_last[k]      = mem_l[k][rd_ptr[k]];
         end else begin
            i_req_valid[k]     = 1'b0;
            i_req_data[k*W +: W] = '0;
            i_req_last[k]      = 1'b0;
         end
      end
   endtask

   // Called at the falling edge: settle this cycle's handshakes, then advance one cycle.
   task automatic step();
      logic [W+2:0] e;
      if (o_valid && i_ready && !i_rst) begin
         out_cnt++;
         n_tests++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_beat observed=0x%0h expected=none", {o_src, o_last, o_data});
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_beat", {o_src, o_last, o_data}, e);
         end
      end
      for (int k = 0; k < N; k++)
         if (i_req_valid[k] && o_req_ready[k] && !i_rst)
            rd_ptr[k]++;
      @(posedge i_clk);
      #1;
      drive_reqs();
      @(negedge i_clk);
   endtask

   task automatic clear_reqs();
      en = '0;
      for (int k = 0; k < N; k++) begin
         rd_ptr[k] = 0;
         wr_cnt[k] = 0;
      end
      drive_reqs();
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      clear_reqs();
      step();
      step();
      i_rst = 1'b0;
   endtask

   task automatic end_scn(input string tag);
      chk(tag, exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      i_rst       = 1'b1;
      i_ready     = 1'b1;
      i_req_valid = '0;
      i_req_data  = '0;
      i_req_last  = '0;
      @(negedge i_clk);
      do_reset();

      // Reset state
      chk("rst_valid", o_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_src", o_src, 0);
      chk("rst_last", o_last, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_ready", o_req_ready, 0);

      // Single requester, three beats
      load(0, 32'hA, 1'b0); load(0, 32'hB, 1'b0); load(0, 32'hC, 1'b1);
      expect_beat(2'd0, 1'b0, 32'hA);
      expect_beat(2'd0, 1'b0, 32'hB);
      expect_beat(2'd0, 1'b1, 32'hC);
      en = 4'b0001; drive_reqs();
      chk("s1_c0_ready", o_req_ready, 0);
      step();
      chk("s1_c1_ready", o_req_ready, 4'b0001);
      chk("s1_c1_busy", o_busy, 1);
      step();
      chk("s1_c2_ready", o_req_ready, 4'b0001);
      chk("s1_c2_valid", o_valid, 1);
      chk("s1_c2_data", o_data, 32'hA);
      chk("s1_c2_last", o_last, 0);
      step();
      chk("s1_c3_data", o_data, 32'hB);
      chk("s1_c3_ready", o_req_ready, 4'b0001);
      step();
      chk("s1_c4_busy", o_busy, 0);
      chk("s1_c4_ready", o_req_ready, 0);
      chk("s1_c4_data", o_data, 32'hC);
      chk("s1_c4_last", o_last, 1);
      step();
      chk("s1_c5_valid", o_valid, 0);
      end_scn("s1_drained");

      // rr_ptr is now 1: req1 wins over req0
      load(0, 32'hD, 1'b1); load(1, 32'hE, 1'b1);
      expect_beat(2'd1, 1'b1, 32'hE);
      expect_beat(2'd0, 1'b1, 32'hD);
      en = 4'b0011; drive_reqs();
      step();
      chk("rr1_ready", o_req_ready, 4'b0010);
      for (int s = 0; s < 5; s++) step();
      end_scn("rr1_drained");

      // All four requesters continuously valid, no last
      do_reset();
      for (int k = 0; k < N; k++)
         for (int j = 0; j < 8; j++)
            load(k, 32'(k * 256 + j), 1'b0);
      for (int g = 0; g < 5; g++)
         for (int j = 0; j < 4; j++)
            expect_beat(2'(g % 4), (j == 3), 32'((g % 4) * 256 + (g / 4) * 4 + j));
      base = out_cnt;
      en = 4'b1111; drive_reqs();
      for (int c = 1; c <= 25; c++) begin
         step();
         chk("s2_busy", o_busy, (c % 5 != 0));
         exp_rdy = (c % 5 != 0) ? (4'b0001 << (((c - 1) / 5) % 4)) : 4'b0000;
         chk("s2_ready", o_req_ready, exp_rdy);
         if (c >= 2) chk("s2_valid", o_valid, (c % 5 != 1));
         if (c % 5 == 0) chk("s2_last", o_last, 1);
         if (c == 22) chk("s2_beats_in_20", out_cnt - base, 16);
      end
      en = '0; drive_reqs();
      step(); step();
      end_scn("s2_drained");

      // Backpressure after the 2nd beat
      do_reset();
      for (int j = 0; j < 4; j++) begin
         load(0, 32'(32'h30 + j), (j == 3));
         expect_beat(2'd0, (j == 3), 32'(32'h30 + j));
      end
      base = out_cnt;
      en = 4'b0001; drive_reqs();
      step(); step(); step();
      i_ready = 1'b0;
      #1;
      for (int s = 0; s < 3; s++) begin
         if (s > 0) step();
         chk("s3_stall_valid", o_valid, 1);
         chk("s3_stall_data", o_data, 32'h31);
         chk("s3_stall_src", o_src, 0);
         chk("s3_stall_last", o_last, 0);
         chk("s3_stall_ready", o_req_ready, 0);
      end
      i_ready = 1'b1;
      #1;
      chk("s3_resume_ready", o_req_ready, 4'b0001);
      for (int s = 0; s < 4; s++) step();
      end_scn("s3_drained");
      chk("s3_beat_count", out_cnt - base, 4);

      // Priority rotation from rr_ptr=2
      do_reset();
      load(1, 32'h41, 1'b1);
      expect_beat(2'd1, 1'b1, 32'h41);
      en = 4'b0010; drive_reqs();
      step(); step(); step();
      load(1, 32'h51, 1'b1); load(3, 32'h53, 1'b1);
      expect_beat(2'd3, 1'b1, 32'h53);
      expect_beat(2'd1, 1'b1, 32'h51);
      en = 4'b1010; drive_reqs();
      step();
      chk("s4_first_grant", o_req_ready, 4'b1000);
      step();
      chk("s4_idle_gap", o_busy, 0);
      step();
      chk("s4_second_grant", o_req_ready, 4'b0010);
      step(); step();
      end_scn("s4_drained");

      // Owner stalls mid-burst while req2 waits
      do_reset();
      for (int j = 0; j < 4; j++) begin
         load(0, 32'(32'h60 + j), 1'b0);
         expect_beat(2'd0, (j == 3), 32'(32'h60 + j));
      end
      load(2, 32'h70, 1'b0); load(2, 32'h71, 1'b1);
      expect_beat(2'd2, 1'b0, 32'h70);
      expect_beat(2'd2, 1'b1, 32'h71);
      en = 4'b0101; drive_reqs();
      step();
      chk("s5_c1_ready", o_req_ready, 4'b0001);
      step();
      en = 4'b0100;
      step();
      chk("s5_stall1_ready", o_req_ready, 4'b0001);
      chk("s5_stall1_busy", o_busy, 1);
      chk("s5_stall1_data", o_data, 32'h61);
      step();
      chk("s5_stall2_ready", o_req_ready, 4'b0001);
      chk("s5_stall2_valid", o_valid, 0);
      chk("s5_stall2_busy", o_busy, 1);
      en = 4'b0101;
      step();
      chk("s5_resume_ready", o_req_ready, 4'b0001);
      step(); step();
      chk("s5_burst_end_data", o_data, 32'h63);
      chk("s5_burst_end_last", o_last, 1);
      chk("s5_burst_end_busy", o_busy, 0);
      step();
      chk("s5_req2_grant", o_req_ready, 4'b0100);
      step(); step(); step();
      end_scn("s5_drained");

      // Reset mid-burst (rr_ptr is 3 going in)
      load(3, 32'h90, 1'b0); load(3, 32'h91, 1'b0);
      load(3, 32'h92, 1'b0); load(3, 32'h93, 1'b1);
      en = 4'b1000; drive_reqs();
      step();
      chk("s6_grant3", o_req_ready, 4'b1000);
      step();
      chk("s6_pre_valid", o_valid, 1);
      chk("s6_pre_data", o_data, 32'h90);
      chk("s6_pre_src", o_src, 3);
      i_rst = 1'b1;
      #1;
      chk("s6_rst_ready", o_req_ready, 0);
      step();
      chk("s6_post_valid", o_valid, 0);
      chk("s6_post_data", o_data, 0);
      chk("s6_post_src", o_src, 0);
      chk("s6_post_last", o_last, 0);
      chk("s6_post_busy", o_busy, 0);
      chk("s6_post_ready", o_req_ready, 0);
      i_rst = 1'b0;
      load(0, 32'hA0, 1'b1);
      expect_beat(2'd0, 1'b1, 32'hA0);
      expect_beat(2'd3, 1'b0, 32'h91);
      expect_beat(2'd3, 1'b0, 32'h92);
      expect_beat(2'd3, 1'b1, 32'h93);
      en = 4'b1001; drive_reqs();
      step();
      chk("s6_regrant0", o_req_ready, 4'b0001);
      step();
      chk("s6_idle", o_busy, 0);
      step();
      chk("s6_regrant3", o_req_ready, 4'b1000);
      step(); step(); step(); step();
      end_scn("s6_drained");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
